// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag definitions for the sequential ALU.
// The CPU control decoder imports the same opcode encodings.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done is high during the final step; result is the product at that moment.
module seq_mul #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic             active;

  // Product modulo 2^WIDTH, so operand signedness is irrelevant.
  assign result = acc + (mplier[0] ? mcand : '0);
  assign done   = active && (count == CW'(WIDTH - 1));

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  // NOTE: the working registers are ordinary flops, so a reset clears them along with control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      active <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc    <= result;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops finish on the
// accepting edge, MUL runs WIDTH cycles through seq_mul.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             carry_flag,
  output logic             ovf_flag
);

  state_e           state, state_next;
  flags_t           flags_q;
  logic             accept, is_mul, load_alu, load_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_result;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_result, res_d;
  logic             alu_carry, alu_ovf, carry_d, ovf_d;

  assign accept   = in_valid && in_ready;
  assign is_mul   = (func == OP_MUL);
  assign load_alu = accept && !is_mul;
  assign load_mul = (state == S_BUSY) && mul_done;

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_mul),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .result (mul_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = is_mul ? S_BUSY : S_DONE;
      S_BUSY:  if (mul_done) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Carry/borrow come from a WIDTH+1 bit unsigned sum/difference.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SHW-1:0];

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (func)
      OP_ADD: begin
        alu_result = sum_ext[WIDTH-1:0];
        alu_carry  = sum_ext[WIDTH];
        alu_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result = diff_ext[WIDTH-1:0];
        alu_carry  = diff_ext[WIDTH];
        alu_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_result = a & b;
      OP_OR:   alu_result = a | b;
      OP_NOR:  alu_result = ~(a | b);
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_result = a << shamt;
      OP_SRL:  alu_result = a >> shamt;
      OP_SRA:  alu_result = $signed(a) >>> shamt;
      default: alu_result = '0;
    endcase
  end

  assign res_d   = load_mul ? mul_result : alu_result;
  assign carry_d = load_mul ? 1'b0 : alu_carry;
  assign ovf_d   = load_mul ? 1'b0 : alu_ovf;

  // Loaded only on completion, so out/flags stay frozen while DONE waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= '0;
      flags_q <= '0;
    end else if (load_alu || load_mul) begin
      out     <= res_d;
      flags_q <= '{zero: (res_d == '0), neg: res_d[WIDTH-1], carry: carry_d, ovf: ovf_d};
    end
  end

  assign zero_flag  = flags_q.zero;
  assign neg_flag   = flags_q.neg;
  assign carry_flag = flags_q.carry;
  assign ovf_flag   = flags_q.ovf;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32) against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   func;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero_flag, neg_flag, carry_flag, ovf_flag;

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .func       (func),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .zero_flag  (zero_flag),
    .neg_flag   (neg_flag),
    .carry_flag (carry_flag),
    .ovf_flag   (ovf_flag)
  );

  always #5 clk = ~clk;

  // Reference: true-integer arithmetic, truncated; overflow = true result not representable.
  function automatic void model(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c, output logic v);
    longint          sx = $signed(x);
    longint          sy = $signed(y);
    longint unsigned ux = x;
    longint unsigned uy = y;
    longint          s;
    logic [4:0]      sh = y[4:0];
    r = '0; c = 1'b0; v = 1'b0;
    case (f)
      4'd0: begin
        r = W'(ux + uy); c = ((ux + uy) >> W) != 0;
        s = sx + sy;     v = (s != longint'($signed(r)));
      end
      4'd1: begin
        r = W'(ux - uy); c = (ux < uy);
        s = sx - sy;     v = (s != longint'($signed(r)));
      end
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = ~(x | y);
      4'd5:  r = (sx < sy) ? 1 : 0;
      4'd6:  r = (ux < uy) ? 1 : 0;
      4'd7:  r = x << sh;
      4'd8:  r = x >> sh;
      4'd9:  r = W'($signed(x) >>> sh);
      4'd10: r = W'(ux * uy);
      default: r = '0;
    endcase
  endfunction

  // Issue one op, scramble inputs after accept, check latency/result/flags,
  // hold out_ready low for `stall` cycles checking stability, then consume.
  task automatic run_op(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int stall, output logic [W-1:0] got, output logic [3:0] got_flags);
    logic [W-1:0] er;
    logic         ec, ev;
    logic [3:0]   ef;
    int           n;
    int           exp_lat;
    logic [W+3:0] snap;
    model(f, x, y, er, ec, ev);
    ef      = {er == '0, er[W-1], ec, ev};
    exp_lat = (f == 4'd10) ? W : 0;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_wait in_ready=%b want 1", in_ready); end
    in_valid = 1'b1; func = f; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; func = 4'($urandom_range(15, 0));
    n = 0;
    while (!out_valid && n < 100) begin
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_ready op=%0d cyc=%0d in_ready=%b want 0", f, n, in_ready); end
      @(posedge clk); #1; n++;
    end
    total++;
    if (n != exp_lat) begin bad++; $display("FAIL latency op=%0d got=%0d want=%0d", f, n, exp_lat); end
    total++;
    if (out !== er) begin bad++; $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", f, x, y, out, er); end
    total++;
    if ({zero_flag, neg_flag, carry_flag, ovf_flag} !== ef)
      begin bad++; $display("FAIL flags op=%0d a=%h b=%h got=%b want=%b", f, x, y, {zero_flag, neg_flag, carry_flag, ovf_flag}, ef); end
    got       = out;
    got_flags = {zero_flag, neg_flag, carry_flag, ovf_flag};
    snap      = {out, zero_flag, neg_flag, carry_flag, ovf_flag};
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, out, zero_flag, neg_flag, carry_flag, ovf_flag} !== {2'b10, snap})
        begin bad++; $display("FAIL hold cyc=%0d valid=%b ready=%b out=%h want valid=1 ready=0 out=%h", i, out_valid, in_ready, out, snap[W+3:4]); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL consume valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; func = '0;
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL reset_hs ready=%b valid=%b want 1/0", in_ready, out_valid); end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out, zero_flag, neg_flag, carry_flag, ovf_flag} !== '0) begin bad++; $display("FAIL reset_out out=%h want 0", out); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL post_reset ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_add_sub();
    logic [W-1:0] r;
    logic [3:0]   fl;
    run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 0, r, fl);
    total++;
    if ({r, fl} !== {32'h8000_0000, 4'b0101}) begin bad++; $display("FAIL add_ovf got=%h/%b want 80000000/0101", r, fl); end
    run_op(4'd1, 32'd5, 32'd5, 0, r, fl);
    total++;
    if ({r, fl} !== {32'h0, 4'b1000}) begin bad++; $display("FAIL sub_zero got=%h/%b want 0/1000", r, fl); end
    run_op(4'd1, 32'd3, 32'd5, 0, r, fl);
    total++;
    if ({r, fl} !== {32'hFFFF_FFFE, 4'b0110}) begin bad++; $display("FAIL sub_borrow got=%h/%b want fffffffe/0110", r, fl); end
    run_op(4'd0, 32'hFFFF_FFFF, 32'h1, 0, r, fl);
    total++;
    if ({r, fl} !== {32'h0, 4'b1010}) begin bad++; $display("FAIL add_carry got=%h/%b want 0/1010", r, fl); end
  endtask

  task automatic test_compare_shift();
    logic [W-1:0] r;
    logic [3:0]   fl;
    run_op(4'd5, 32'hFFFF_FFFF, 32'h1, 0, r, fl);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL slt got=%h want 1", r); end
    run_op(4'd6, 32'hFFFF_FFFF, 32'h1, 0, r, fl);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL sltu got=%h want 0", r); end
    run_op(4'd9, 32'h8000_0000, 32'd4, 0, r, fl);
    total++; if (r !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%h want f8000000", r); end
    run_op(4'd7, 32'h0000_0003, 32'h25, 0, r, fl);
    total++; if (r !== 32'h60) begin bad++; $display("FAIL sll_mask got=%h want 60", r); end
    run_op(4'd8, 32'hDEAD_BEEF, 32'h0, 0, r, fl);
    total++; if (r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL srl_zero got=%h want deadbeef", r); end
    run_op(4'd13, 32'h1234_5678, 32'h9, 0, r, fl);
    total++; if ({r, fl} !== {32'h0, 4'b1000}) begin bad++; $display("FAIL undef_op got=%h/%b want 0/1000", r, fl); end
  endtask

  task automatic test_mul();
    logic [W-1:0] r;
    logic [3:0]   fl;
    run_op(4'd10, 32'h0001_0001, 32'h0001_0001, 0, r, fl);
    total++; if (r !== 32'h0002_0001) begin bad++; $display("FAIL mul got=%h want 00020001", r); end
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, fl);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL mul_neg got=%h want 1", r); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r;
    logic [3:0]   fl;
    run_op(4'd0, 32'h1234_0000, 32'h0000_5678, 5, r, fl);
    total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL bp_add got=%h want 12345678", r); end
  endtask

  task automatic test_reset_mid_mul();
    logic [W-1:0] r;
    logic [3:0]   fl;
    in_valid = 1'b1; func = 4'd10; a = 32'hFFFF; b = 32'hFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b00) begin bad++; $display("FAIL mid_mul ready=%b valid=%b want 0/0", in_ready, out_valid); end
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, out, zero_flag, neg_flag, carry_flag, ovf_flag} !== {2'b10, 36'h0})
      begin bad++; $display("FAIL rst_mul ready=%b valid=%b out=%h want 1/0/0", in_ready, out_valid, out); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(4'd0, 32'd2, 32'd3, 0, r, fl);
    total++; if (r !== 32'd5) begin bad++; $display("FAIL add_after_rst got=%h want 5", r); end
  endtask

  task automatic test_random();
    logic [W-1:0] r, x, y;
    logic [3:0]   fl, f;
    for (int i = 0; i < 40; i++) begin
      f = 4'($urandom_range(15, 0));
      x = $urandom;
      y = (i % 4 == 0) ? x : $urandom;
      run_op(f, x, y, $urandom_range(2, 0), r, fl);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_compare_shift();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width; not overridden independently.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; for shifts only b[SHW-1:0] is used.
REQ-009 func  input  4  opcode, encoding per REQ-013.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out  output  WIDTH  result; zero_flag, neg_flag, carry_flag, ovf_flag  output  1 each  result flags.

Function
REQ-013 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low WIDTH bits of the product); 11-15 produce out=0.
REQ-014 FSM states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept when in_valid&in_ready at an edge; operands and func are captured at that edge and later input changes are ignored.
REQ-016 Non-MUL accept: IDLE->DONE; out_valid high in the cycle after the accepting edge (latency 1).
REQ-017 MUL accept: IDLE->BUSY; iterative shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY; out_valid asserted after edge k+WIDTH, where k is the accepting edge.
REQ-018 DONE: out and flags SHALL be held stable while out_valid=1 and out_ready=0.
REQ-019 On out_valid&out_ready: DONE->IDLE; out_valid low the next cycle; no new request is accepted in the same cycle (in_ready=0 in DONE).
REQ-020 zero_flag = (out==0) for all opcodes; neg_flag = out[WIDTH-1] for all opcodes.
REQ-021 carry_flag: ADD carry-out of bit WIDTH-1; SUB borrow (1 when a<b unsigned); 0 for all other opcodes.
REQ-022 ovf_flag: signed overflow for ADD/SUB; 0 for all other opcodes.
REQ-023 SLT/SLTU out = {WIDTH-1 zeros, compare bit}; SRA sign-fills; shift amount 0 returns a unchanged.
REQ-024 MUL result SHALL equal (a*b) mod 2^WIDTH irrespective of operand signs.
REQ-025 out and flags SHALL be don't-care while out_valid=0; the bench checks them only when out_valid=1.

Reset
REQ-026 rst asserted at any time, including mid-BUSY or in DONE, SHALL immediately force state IDLE, out_valid=0, out=0, all flags=0, and clear the multiplier registers; in-flight work is discarded.
REQ-027 in_ready SHALL be 1 during and after reset (state IDLE).

Structure
REQ-028 Opcode constants and FSM state encodings SHALL live in a shared package, alu_pkg, for reuse by the CPU control decoder.
REQ-029 The iterative multiplier SHALL be a sub-module, seq_mul (start/done, WIDTH-parametrised); all other operations stay in seq_alu.

Verification (WIDTH=32)
REQ-030 ADD a=0x7FFFFFFF b=1 -> 1 cycle later: out=0x80000000, ovf=1, neg=1, carry=0, zero=0.
REQ-031 SUB a=5 b=5 -> out=0, zero=1, carry=0; SUB a=3 b=5 -> out=0xFFFFFFFE, carry=1, neg=1.
REQ-032 MUL a=0x00010001 b=0x00010001 -> in_ready=0 for 32 BUSY cycles; out=0x00020001 valid at accept+32; changing a/b during BUSY has no effect.
REQ-033 SLT a=0xFFFFFFFF b=1 -> out=1; SLTU with same operands -> out=0; SRA a=0x80000000 b=4 -> out=0xF8000000; SLL by b=0x25 uses amount 5.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles after an ADD completes -> out, flags and out_valid stable and in_ready=0; the result is consumed on the first out_ready=1 cycle.
REQ-035 Assert rst 10 cycles into a MUL -> out_valid=0 and in_ready=1 immediately; a following ADD 2+3 returns 5 with latency 1.
